// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (counters, DE, syncs, line/frame
// pulses, frame counter) plus a delay-matched output stage that realigns the
// renderer's RGB with the sync/DE signals and blanks it outside the active area.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIPE_DLY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        video_active,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  input  logic [5:0]  rgb_in,
  output logic [5:0]  rgb_out,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o
);

  // Totals must fit the 11-bit counters (<= 2048).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  // Pipeline word layout: {hsync, vsync, de, rgb[5:0]}
  localparam logic [8:0] PIPE_RST = {~HS_ON, ~VS_ON, 1'b0, 6'd0};

  logic [10:0] x_next;
  logic [10:0] y_next;
  logic        x_wrap;
  logic        frame_next;
  logic [8:0]  pipe_in;
  logic [8:0]  pipe_reg [PIPE_DLY];

  // Next raster position; decode is taken from this so every registered
  // output describes the same pixel as pix_x/pix_y in the same cycle.
  always_comb begin
    x_wrap = (pix_x == H_LAST);
    x_next = x_wrap ? 11'd0 : pix_x + 11'd1;
    y_next = pix_y;
    if (x_wrap) begin
      y_next = (pix_y == V_LAST) ? 11'd0 : pix_y + 11'd1;
    end
    frame_next = (x_next == 11'd0) && (y_next == 11'd0);
  end

  // Counters and decoded timing signals, all registered and advanced only on en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x        <= H_LAST;
      pix_y        <= V_LAST;
      video_active <= 1'b0;
      hsync        <= ~HS_ON;
      vsync        <= ~VS_ON;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      frame_cnt    <= 16'd0;
    end else if (en) begin
      pix_x        <= x_next;
      pix_y        <= y_next;
      video_active <= (x_next < H_VIS) && (y_next < V_VIS);
      hsync        <= ((x_next >= HS_START) && (x_next <= HS_END)) ? HS_ON : ~HS_ON;
      vsync        <= ((y_next >= VS_START) && (y_next <= VS_END)) ? VS_ON : ~VS_ON;
      line_start   <= (x_next == 11'd0);
      frame_start  <= frame_next;
      if (frame_next) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // RGB is blanked on entry so the last stage can drive the pins directly.
  assign pipe_in = {hsync, vsync, video_active, video_active ? rgb_in : 6'd0};

  // Output delay line; stalls together with the counters when en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_DLY; i++) begin
        pipe_reg[i] <= PIPE_RST;
      end
    end else if (en) begin
      pipe_reg[0] <= pipe_in;
      for (int i = 1; i < PIPE_DLY; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  assign {hsync_o, vsync_o, de_o, rgb_out} = pipe_reg[PIPE_DLY-1];

endmodule
